// File: rtl/axi_modify_id_ctrl.sv
// ---------------------------------------------------------------------------
// axi_modify_id_ctrl
//
// Purpose:
//   ID allocator that feeds the replacement-ID inputs of an AXI ID-modify
//   connector. Wide slave-port IDs are remapped onto a small table of
//   master-port IDs, one table for writes (AW/B) and one for reads (AR/R).
//   Each table slot keeps a busy bit, the original slave ID and a count of
//   outstanding transactions. Responses are translated back to the original
//   slave ID by a combinational lookup. AW/AR handshakes are gated whenever
//   no master ID can be granted.
//
// Optional feature (macro AXI_MODIFY_ID_CTRL_ERR_EN):
//   Adds err_o / err_clr_i. err_o latches on a response to a non-busy slot
//   or an increment past MaxTxnsPerId, and clears on err_clr_i (set wins).
//   Without the macro those ports are absent and unmapped responses are
//   silently ignored.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   slv_aw_valid_i/slv_aw_id_i   AW request from slave port
//   slv_aw_ready_o               gated AW ready towards slave port
//   mst_aw_valid_o/mst_aw_id_o   gated AW valid and allocated ID to master
//   mst_aw_ready_i               AW ready from master port
//   slv_ar_* / mst_ar_*          same as AW for the read table
//   mst_b_valid_i/slv_b_ready_i  B handshake (decrements write slot)
//   mst_b_id_i -> slv_b_id_o     B ID lookup
//   mst_r_valid_i/slv_r_ready_i/mst_r_last_i  R handshake, last beat frees
//   mst_r_id_i -> slv_r_id_o     R ID lookup
//   wr_full_o / rd_full_o        every slot of the table is busy
// ---------------------------------------------------------------------------
module axi_modify_id_ctrl #(
    parameter int SlvIdWidth   = 4,
    parameter int MstIdWidth   = 2,
    parameter int MaxTxnsPerId = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef AXI_MODIFY_ID_CTRL_ERR_EN
    input  logic                  err_clr_i,
    output logic                  err_o,
`endif
    input  logic                  slv_aw_valid_i,
    input  logic [SlvIdWidth-1:0] slv_aw_id_i,
    output logic                  slv_aw_ready_o,
    output logic                  mst_aw_valid_o,
    input  logic                  mst_aw_ready_i,
    output logic [MstIdWidth-1:0] mst_aw_id_o,
    input  logic                  slv_ar_valid_i,
    input  logic [SlvIdWidth-1:0] slv_ar_id_i,
    output logic                  slv_ar_ready_o,
    output logic                  mst_ar_valid_o,
    input  logic                  mst_ar_ready_i,
    output logic [MstIdWidth-1:0] mst_ar_id_o,
    input  logic                  mst_b_valid_i,
    input  logic                  slv_b_ready_i,
    input  logic [MstIdWidth-1:0] mst_b_id_i,
    output logic [SlvIdWidth-1:0] slv_b_id_o,
    input  logic                  mst_r_valid_i,
    input  logic                  slv_r_ready_i,
    input  logic                  mst_r_last_i,
    input  logic [MstIdWidth-1:0] mst_r_id_i,
    output logic [SlvIdWidth-1:0] slv_r_id_o,
    output logic                  wr_full_o,
    output logic                  rd_full_o
);

    localparam int NumSlots = 2 ** MstIdWidth;
    localparam int CntWidth = $clog2(MaxTxnsPerId + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxnsPerId);
    localparam logic [CntWidth-1:0] OneCnt = CntWidth'(1);
    localparam int WR = 0;
    localparam int RD = 1;

    // Both directions share one table implementation; index 0 is the write
    // table (AW/B), index 1 the read table (AR/R).
    logic [1:0]                 w_req_valid;
    logic [1:0][SlvIdWidth-1:0] w_req_id;
    logic [1:0]                 w_mst_ready;
    logic [1:0]                 w_mst_valid;
    logic [1:0]                 w_req_ready;
    logic [1:0][MstIdWidth-1:0] w_mst_id;
    logic [1:0]                 w_rsp_dec;
    logic [1:0][MstIdWidth-1:0] w_rsp_slot;
    logic [1:0][SlvIdWidth-1:0] w_rsp_id;
    logic [1:0]                 w_full;
`ifdef AXI_MODIFY_ID_CTRL_ERR_EN
    logic [1:0]                 w_err;
`endif

    assign w_req_valid[WR] = slv_aw_valid_i;
    assign w_req_valid[RD] = slv_ar_valid_i;
    assign w_req_id[WR]    = slv_aw_id_i;
    assign w_req_id[RD]    = slv_ar_id_i;
    assign w_mst_ready[WR] = mst_aw_ready_i;
    assign w_mst_ready[RD] = mst_ar_ready_i;
    // Writes retire on every B handshake, reads only on the last R beat.
    assign w_rsp_dec[WR]   = mst_b_valid_i & slv_b_ready_i;
    assign w_rsp_dec[RD]   = mst_r_valid_i & slv_r_ready_i & mst_r_last_i;
    assign w_rsp_slot[WR]  = mst_b_id_i;
    assign w_rsp_slot[RD]  = mst_r_id_i;

    assign mst_aw_valid_o = w_mst_valid[WR];
    assign slv_aw_ready_o = w_req_ready[WR];
    assign mst_aw_id_o    = w_mst_id[WR];
    assign mst_ar_valid_o = w_mst_valid[RD];
    assign slv_ar_ready_o = w_req_ready[RD];
    assign mst_ar_id_o    = w_mst_id[RD];
    assign slv_b_id_o     = w_rsp_id[WR];
    assign slv_r_id_o     = w_rsp_id[RD];
    assign wr_full_o      = w_full[WR];
    assign rd_full_o      = w_full[RD];

    genvar gd;
    genvar gi;
    generate
        for (gd = 0; gd < 2; gd++) begin : gen_dir
            logic [NumSlots-1:0]                 w_busy;
            logic [NumSlots-1:0][SlvIdWidth-1:0] w_id;
            logic [NumSlots-1:0][CntWidth-1:0]   w_cnt;
            logic                                w_hit;
            logic                                w_free;
            logic [MstIdWidth-1:0]               w_hit_idx;
            logic [MstIdWidth-1:0]               w_free_idx;
            logic [MstIdWidth-1:0]               w_slot;
            logic                                w_grant;
            logic                                w_inc;

            // Allocation looks only at registered state and the request ID,
            // so the stall decision cannot change while valid is held.
            // Scanning from the top lets the lowest index win both searches.
            always_comb begin
                w_hit      = 1'b0;
                w_free     = 1'b0;
                w_hit_idx  = '0;
                w_free_idx = '0;
                for (int i = NumSlots - 1; i >= 0; i--) begin
                    if (w_busy[i] && (w_id[i] == w_req_id[gd])) begin
                        w_hit     = 1'b1;
                        w_hit_idx = MstIdWidth'(i);
                    end
                    if (!w_busy[i]) begin
                        w_free     = 1'b1;
                        w_free_idx = MstIdWidth'(i);
                    end
                end
            end

            // A busy ID must stay on its slot for ordering, so a hit at the
            // outstanding limit stalls instead of falling back to a free slot.
            assign w_grant = w_hit ? (w_cnt[w_hit_idx] < MaxCnt) : w_free;
            assign w_slot  = w_hit ? w_hit_idx : w_free_idx;

            assign w_mst_valid[gd] = w_req_valid[gd] & w_grant & ~rst_i;
            assign w_req_ready[gd] = w_mst_ready[gd] & w_grant & ~rst_i;
            assign w_mst_id[gd]    = w_slot;
            assign w_inc           = w_mst_valid[gd] & w_mst_ready[gd];

            assign w_rsp_id[gd] = w_id[w_rsp_slot[gd]];
            assign w_full[gd]   = &w_busy;

`ifdef AXI_MODIFY_ID_CTRL_ERR_EN
            // The over-limit term cannot fire while the grant logic holds; it
            // is kept as a guard against a broken handshake upstream.
            assign w_err[gd] = (w_rsp_dec[gd] && !w_busy[w_rsp_slot[gd]]) ||
                               (w_inc && w_hit && (w_cnt[w_hit_idx] >= MaxCnt));
`endif

            for (gi = 0; gi < NumSlots; gi++) begin : gen_slot
                logic                  r_busy;
                logic [SlvIdWidth-1:0] r_id;
                logic [CntWidth-1:0]   r_cnt;
                logic                  w_inc_here;
                logic                  w_dec_here;

                assign w_inc_here = w_inc && (w_slot == MstIdWidth'(gi));
                assign w_dec_here = w_rsp_dec[gd] && (w_rsp_slot[gd] == MstIdWidth'(gi));

                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_busy <= 1'b0;
                        r_id   <= '0;
                        r_cnt  <= '0;
                    end else if (w_inc_here && w_dec_here && r_busy) begin
                        // One in, one out: count and busy are unchanged.
                        r_cnt <= r_cnt;
                    end else if (w_inc_here) begin
                        if (!r_busy) begin
                            r_busy <= 1'b1;
                            r_id   <= w_req_id[gd];
                            r_cnt  <= OneCnt;
                        end else begin
                            r_cnt <= r_cnt + OneCnt;
                        end
                    end else if (w_dec_here && r_busy) begin
                        // Responses to an idle slot are dropped (no underflow).
                        r_cnt <= r_cnt - OneCnt;
                        if (r_cnt == OneCnt) begin
                            r_busy <= 1'b0;
                        end
                    end
                end

                assign w_busy[gi] = r_busy;
                assign w_id[gi]   = r_id;
                assign w_cnt[gi]  = r_cnt;
            end
        end
    endgenerate

`ifdef AXI_MODIFY_ID_CTRL_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (|w_err) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_axi_modify_id_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_modify_id_ctrl
//
// Directed stimulus for axi_modify_id_ctrl. A bench-side model keeps one
// outstanding-count and stored-ID entry per slot and derives every output
// from those counts each cycle; a compare process checks the DUT against it
// on every falling edge. Directed steps add literal expectations that pin
// the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_axi_modify_id_ctrl;

    localparam int SW   = 4;
    localparam int MW   = 2;
    localparam int MAXT = 4;
    localparam int NS   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          slv_aw_valid = 1'b0, mst_aw_ready = 1'b0;
    logic [SW-1:0] slv_aw_id = '0;
    logic          slv_ar_valid = 1'b0, mst_ar_ready = 1'b0;
    logic [SW-1:0] slv_ar_id = '0;
    logic          mst_b_valid = 1'b0, slv_b_ready = 1'b0;
    logic [MW-1:0] mst_b_id = '0;
    logic          mst_r_valid = 1'b0, slv_r_ready = 1'b0, mst_r_last = 1'b0;
    logic [MW-1:0] mst_r_id = '0;
    logic          err_clr = 1'b0;

    logic          slv_aw_ready, mst_aw_valid, slv_ar_ready, mst_ar_valid;
    logic [MW-1:0] mst_aw_id, mst_ar_id;
    logic [SW-1:0] slv_b_id, slv_r_id;
    logic          wr_full, rd_full;
`ifdef AXI_MODIFY_ID_CTRL_ERR_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    axi_modify_id_ctrl #(
        .SlvIdWidth  (SW),
        .MstIdWidth  (MW),
        .MaxTxnsPerId(MAXT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
`ifdef AXI_MODIFY_ID_CTRL_ERR_EN
        .err_clr_i     (err_clr),
        .err_o         (err),
`endif
        .slv_aw_valid_i(slv_aw_valid),
        .slv_aw_id_i   (slv_aw_id),
        .slv_aw_ready_o(slv_aw_ready),
        .mst_aw_valid_o(mst_aw_valid),
        .mst_aw_ready_i(mst_aw_ready),
        .mst_aw_id_o   (mst_aw_id),
        .slv_ar_valid_i(slv_ar_valid),
        .slv_ar_id_i   (slv_ar_id),
        .slv_ar_ready_o(slv_ar_ready),
        .mst_ar_valid_o(mst_ar_valid),
        .mst_ar_ready_i(mst_ar_ready),
        .mst_ar_id_o   (mst_ar_id),
        .mst_b_valid_i (mst_b_valid),
        .slv_b_ready_i (slv_b_ready),
        .mst_b_id_i    (mst_b_id),
        .slv_b_id_o    (slv_b_id),
        .mst_r_valid_i (mst_r_valid),
        .slv_r_ready_i (slv_r_ready),
        .mst_r_last_i  (mst_r_last),
        .mst_r_id_i    (mst_r_id),
        .slv_r_id_o    (slv_r_id),
        .wr_full_o     (wr_full),
        .rd_full_o     (rd_full)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: outstanding count + stored ID per slot -------
    int m_wcnt[NS] = '{default: 0};
    int m_wid [NS] = '{default: 0};
    int m_rcnt[NS] = '{default: 0};
    int m_rid [NS] = '{default: 0};
    bit m_err = 1'b0;

    function automatic int m_cnt(input bit rd, input int i);
        return rd ? m_rcnt[i] : m_wcnt[i];
    endfunction

    // Which slot a request would use, and whether it may proceed.
    function automatic void m_alloc(input bit rd, input int req, output bit grant, output int slot);
        int hit  = -1;
        int free = -1;
        for (int i = 0; i < NS; i++) begin
            if (m_cnt(rd, i) > 0 && (rd ? m_rid[i] : m_wid[i]) == req && hit < 0) hit = i;
            if (m_cnt(rd, i) == 0 && free < 0) free = i;
        end
        if (hit >= 0) begin
            grant = (m_cnt(rd, hit) < MAXT);
            slot  = hit;
        end else if (free >= 0) begin
            grant = 1'b1;
            slot  = free;
        end else begin
            grant = 1'b0;
            slot  = 0;
        end
    endfunction

    function automatic int inc_slot(input bit rd);
        bit g;
        int s;
        m_alloc(rd, rd ? int'(slv_ar_id) : int'(slv_aw_id), g, s);
        if (rd) return (slv_ar_valid && mst_ar_ready && g) ? s : -1;
        return (slv_aw_valid && mst_aw_ready && g) ? s : -1;
    endfunction

    function automatic int dec_slot(input bit rd);
        if (rd) return (mst_r_valid && slv_r_ready && mst_r_last) ? int'(mst_r_id) : -1;
        return (mst_b_valid && slv_b_ready) ? int'(mst_b_id) : -1;
    endfunction

    function automatic int next_cnt(input bit rd, input int i);
        int c = m_cnt(rd, i);
        return c + ((inc_slot(rd) == i) ? 1 : 0) - ((dec_slot(rd) == i && c > 0) ? 1 : 0);
    endfunction

    function automatic bit err_set();
        bit e = 1'b0;
        if (dec_slot(0) >= 0 && m_wcnt[dec_slot(0)] == 0) e = 1'b1;
        if (dec_slot(1) >= 0 && m_rcnt[dec_slot(1)] == 0) e = 1'b1;
        return e;
    endfunction

    function automatic bit m_full(input bit rd);
        for (int i = 0; i < NS; i++) if (m_cnt(rd, i) == 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_wcnt[i] <= 0; m_wid[i] <= 0; m_rcnt[i] <= 0; m_rid[i] <= 0;
            end
            m_err <= 1'b0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                m_wcnt[i] <= next_cnt(0, i);
                m_rcnt[i] <= next_cnt(1, i);
                if (inc_slot(0) == i && m_wcnt[i] == 0) m_wid[i] <= int'(slv_aw_id);
                if (inc_slot(1) == i && m_rcnt[i] == 0) m_rid[i] <= int'(slv_ar_id);
            end
            m_err <= err_set() ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
    end

    // ---------------- per-cycle compare against the model -----------------
    always @(negedge clk) begin
        bit gw, gr;
        int sw, sr;
        m_alloc(0, int'(slv_aw_id), gw, sw);
        m_alloc(1, int'(slv_ar_id), gr, sr);
        chk("mst_aw_valid", mst_aw_valid, !rst && slv_aw_valid && gw);
        chk("slv_aw_ready", slv_aw_ready, !rst && mst_aw_ready && gw);
        chk("mst_aw_id", mst_aw_id, sw);
        chk("mst_ar_valid", mst_ar_valid, !rst && slv_ar_valid && gr);
        chk("slv_ar_ready", slv_ar_ready, !rst && mst_ar_ready && gr);
        chk("mst_ar_id", mst_ar_id, sr);
        chk("slv_b_id", slv_b_id, m_wid[mst_b_id]);
        chk("slv_r_id", slv_r_id, m_rid[mst_r_id]);
        chk("wr_full", wr_full, m_full(0));
        chk("rd_full", rd_full, m_full(1));
`ifdef AXI_MODIFY_ID_CTRL_ERR_EN
        chk("err", err, m_err);
`endif
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ---------
    initial begin
        logic [SW-1:0] ids [4];
        ids[0] = 4'h5; ids[1] = 4'h9; ids[2] = 4'h3; ids[3] = 4'hC;

        // Reset: gated outputs stay low even with requests pending.
        slv_aw_valid = 1'b1; mst_aw_ready = 1'b1; slv_aw_id = 4'h5;
        @(negedge clk);
        chk("rst_aw_valid", mst_aw_valid, 0);
        chk("rst_aw_ready", slv_aw_ready, 0);
        chk("rst_aw_id", mst_aw_id, 0);
        chk("rst_b_id", slv_b_id, 0);
        chk("rst_wr_full", wr_full, 0);
        slv_aw_valid = 1'b0;
        next_cycle();
        rst = 1'b0;

        // Four distinct AW IDs fill the write table; a fifth stalls.
        slv_aw_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            slv_aw_id = ids[k];
            @(negedge clk);
            chk("fill_aw_id", mst_aw_id, k);
            chk("fill_aw_valid", mst_aw_valid, 1);
            next_cycle();
        end
        slv_aw_id = 4'h7;
        @(negedge clk);
        chk("full_wr_full", wr_full, 1);
        chk("full_aw_valid", mst_aw_valid, 0);
        chk("full_aw_ready", slv_aw_ready, 0);
        next_cycle();
        slv_aw_valid = 1'b0;

        // Drain with one B per slot; lookup restores each original ID.
        mst_b_valid = 1'b1; slv_b_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mst_b_id = MW'(k);
            @(negedge clk);
            chk("drain_b_id", slv_b_id, ids[k]);
            next_cycle();
        end
        mst_b_valid = 1'b0;
        @(negedge clk);
        chk("drain_wr_full", wr_full, 0);
        next_cycle();

        // Same ID four times shares slot 0; the fifth waits for a B.
        slv_aw_valid = 1'b1; slv_aw_id = 4'h5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("same_aw_id", mst_aw_id, 0);
            chk("same_aw_valid", mst_aw_valid, 1);
            next_cycle();
        end
        @(negedge clk);
        chk("limit_aw_valid", mst_aw_valid, 0);
        #1;
        mst_b_valid = 1'b1; mst_b_id = 2'd0;
        #1;
        chk("limit_b_id", slv_b_id, 4'h5);
        chk("limit_aw_ready", slv_aw_ready, 0);
        next_cycle();
        mst_b_valid = 1'b0;
        @(negedge clk);
        chk("limit_retry_valid", mst_aw_valid, 1);
        chk("limit_retry_id", mst_aw_id, 0);
        next_cycle();
        slv_aw_valid = 1'b0;
        mst_b_valid = 1'b1;
        for (int k = 0; k < 4; k++) next_cycle();
        mst_b_valid = 1'b0;

        // Read burst: slot frees only after the last beat.
        slv_ar_valid = 1'b1; mst_ar_ready = 1'b1; slv_ar_id = 4'hA;
        @(negedge clk);
        chk("ar_id_a", mst_ar_id, 0);
        next_cycle();
        slv_ar_valid = 1'b0;
        mst_r_valid = 1'b1; slv_r_ready = 1'b1; mst_r_id = 2'd0; mst_r_last = 1'b0;
        @(negedge clk);
        chk("r_beat1_id", slv_r_id, 4'hA);
        next_cycle();
        mst_r_last = 1'b1;
        slv_ar_valid = 1'b1; slv_ar_id = 4'hB; mst_ar_ready = 1'b0;
        @(negedge clk);
        chk("r_beat2_id", slv_r_id, 4'hA);
        chk("ar_b_slot_busy", mst_ar_id, 1);
        next_cycle();
        mst_r_valid = 1'b0; mst_ar_ready = 1'b1;
        @(negedge clk);
        chk("ar_b_slot_freed", mst_ar_id, 0);
        next_cycle();
        slv_ar_valid = 1'b0;
        mst_r_valid = 1'b1;
        @(negedge clk);
        chk("r_id_b", slv_r_id, 4'hB);
        next_cycle();
        mst_r_valid = 1'b0; mst_r_last = 1'b0;

        // Simultaneous AW hit and B on slot 1 keeps it busy.
        slv_aw_valid = 1'b1; slv_aw_id = 4'h5;
        next_cycle();
        slv_aw_id = 4'h9;
        @(negedge clk);
        chk("hit_setup_id", mst_aw_id, 1);
        next_cycle();
        mst_b_valid = 1'b1; mst_b_id = 2'd1;
        @(negedge clk);
        chk("hit_dec_aw_id", mst_aw_id, 1);
        chk("hit_dec_aw_valid", mst_aw_valid, 1);
        chk("hit_dec_b_id", slv_b_id, 4'h9);
        next_cycle();
        slv_aw_valid = 1'b0;
        @(negedge clk);
        chk("hit_dec_b_id2", slv_b_id, 4'h9);
        next_cycle();
        mst_b_valid = 1'b0;
        slv_aw_valid = 1'b1; slv_aw_id = 4'h6;
        @(negedge clk);
        chk("hit_dec_freed", mst_aw_id, 1);
        next_cycle();
        slv_aw_id = 4'h8;
        @(negedge clk);
        chk("wr_slot2", mst_aw_id, 2);
        next_cycle();
        slv_aw_valid = 1'b0;

        // Two read slots busy, then reset mid-operation.
        slv_ar_valid = 1'b1; slv_ar_id = 4'h1;
        next_cycle();
        slv_ar_id = 4'h2;
        @(negedge clk);
        chk("rd_slot1", mst_ar_id, 1);
        next_cycle();
        slv_aw_valid = 1'b1; slv_aw_id = 4'hF;
        mst_b_valid = 1'b1; slv_b_ready = 1'b0; mst_b_id = 2'd1;
        mst_r_id = 2'd1;
        #1;
        chk("pre_rst_b_id", slv_b_id, 4'h6);
        rst = 1'b1;
        #1;
        chk("rst_now_aw_valid", mst_aw_valid, 0);
        chk("rst_now_aw_ready", slv_aw_ready, 0);
        chk("rst_now_ar_valid", mst_ar_valid, 0);
        chk("rst_now_aw_id", mst_aw_id, 0);
        chk("rst_now_b_id", slv_b_id, 0);
        chk("rst_now_r_id", slv_r_id, 0);
        next_cycle();
        mst_b_valid = 1'b0; slv_b_ready = 1'b1; slv_ar_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_aw_id", mst_aw_id, 0);
        chk("post_rst_aw_valid", mst_aw_valid, 1);
        next_cycle();
        slv_aw_valid = 1'b0;

        // Response to a free slot: ignored by the table, flagged when enabled.
        mst_b_valid = 1'b1; mst_b_id = 2'd2;
        next_cycle();
        mst_b_valid = 1'b0;
`ifdef AXI_MODIFY_ID_CTRL_ERR_EN
        @(negedge clk);
        chk("err_set", err, 1);
        #1;
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", err, 0);
`endif
        slv_aw_valid = 1'b1; slv_aw_id = 4'h4;
        @(negedge clk);
        chk("unmapped_no_underflow", mst_aw_id, 1);
        next_cycle();
        slv_aw_valid = 1'b0;

        repeat (3) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
